// File: rtl/led_arbiter.sv
// Round-robin time-slice arbiter that shares one 8-LED bank between four requesters.
// The winner owns the bank for at most 2^SLICE_BITS cycles. Every release is followed by one idle cycle.
module led_arbiter #(
  parameter int unsigned SLICE_BITS   = 20,
  parameter logic [7:0]  IDLE_PATTERN = 8'h00
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [31:0] src_data,
  output logic [3:0]  gnt,
  output logic [7:0]  leds,
  output logic        busy,
  output logic        expired
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e                state_q;
  logic [1:0]            owner_q;
  logic [1:0]            ptr_q;
  logic [SLICE_BITS-1:0] cnt_q;
  logic [3:0]            gnt_q;
  logic [7:0]            leds_q;

  logic [1:0]            owner_d;
  logic                  grant_d;
  logic [1:0]            idx;
  logic [7:0]            lane_owner;
  logic                  slice_end;

  // First set request bit, searched from ptr upward (mod 4).
  always_comb begin
    owner_d = '0;
    grant_d = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!grant_d && req[idx]) begin
        owner_d = idx;
        grant_d = 1'b1;
      end
    end
  end

  assign lane_owner = src_data[{owner_q, 3'b000} +: 8];
  assign slice_end  = (cnt_q == '1);

  // Decoded from the registered count so that an early release on the final cycle suppresses the pulse.
  assign expired = (state_q == S_GRANT) && req[owner_q] && slice_end;
  assign gnt     = gnt_q;
  assign leds    = leds_q;
  assign busy    = |gnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      leds_q  <= IDLE_PATTERN;
    end else begin
      case (state_q)
        S_IDLE: begin
          leds_q <= IDLE_PATTERN;
          if (grant_d) begin
            owner_q <= owner_d;
            gnt_q   <= 4'b0001 << owner_d;
            cnt_q   <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          leds_q <= lane_owner;
          if (!req[owner_q] || slice_end) begin
            gnt_q   <= '0;
            ptr_q   <= owner_q + 2'd1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + SLICE_BITS'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
